div_share_arbiter: RTL and testbench

//  Shares one fully pipelined divide_ip (fixed latency) between N_REQ requesters, e.g. the

---
 rtl/div_share_arbiter_pkg.sv | 29 ++
 rtl/div_share_arbiter_if.sv | 30 +++
 rtl/div_share_arbiter_rr_arbiter.sv | 29 ++
 rtl/div_share_arbiter.sv | 117 +++++++++++
 tb/tb_div_share_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_share_arbiter_pkg.sv
// Shared types and defaults for the divider-sharing arbiter.
// The tag follows each issued op through the divider latency.
package div_arb_pkg;

    localparam int N_REQ_DEF       = 2;
    localparam int NUMER_W_DEF     = 23;
    localparam int DENOM_W_DEF     = 15;
    localparam int QUOT_W_DEF      = 11;
    localparam int DIV_LATENCY_DEF = 5;

    typedef struct packed {
        logic       vld;
        logic [2:0] id;
        logic       dbz;
    } div_tag_t;

    // One-hot of id, restricted to the low n positions.
    function automatic logic [7:0] onehot(input logic [2:0] id, input int n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if ((i < n) && (id == 3'(i))) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// Requester-side bundle: operand handshake plus the shared response bus.
// slave = arbiter side, master = requester side.
interface div_share_arbiter_if
    import div_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int NUMER_W = NUMER_W_DEF,
    parameter int DENOM_W = DENOM_W_DEF,
    parameter int QUOT_W  = QUOT_W_DEF
);

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*NUMER_W-1:0] req_numer;
    logic [N_REQ*DENOM_W-1:0] req_denom;
    logic [N_REQ-1:0]         resp_valid;
    logic [QUOT_W-1:0]        resp_quot;
    logic                     resp_dbz;

    modport slave (
        input  req_valid, req_numer, req_denom,
        output req_ready, resp_valid, resp_quot, resp_dbz
    );

    modport master (
        output req_valid, req_numer, req_denom,
        input  req_ready, resp_valid, resp_quot, resp_dbz
    );

endinterface

// File: rtl/div_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one fixed-latency pipelined divider among N_REQ requesters, round-robin,
// tagging each op so its quotient is routed back to the owner DIV_LATENCY+1 edges later.
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int NUMER_W     = NUMER_W_DEF,
    parameter int DENOM_W     = DENOM_W_DEF,
    parameter int QUOT_W      = QUOT_W_DEF,
    parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    div_share_arbiter_if.slave  bus,
    output logic [NUMER_W-1:0]  div_numer,
    output logic [DENOM_W-1:0]  div_denom,
    input  logic [QUOT_W-1:0]   div_quot,
    output logic                busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic [NUMER_W-1:0] numer_arr [N_REQ];
    logic [DENOM_W-1:0] denom_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign numer_arr[gi] = bus.req_numer[gi*NUMER_W +: NUMER_W];
            assign denom_arr[gi] = bus.req_denom[gi*DENOM_W +: DENOM_W];
        end
    endgenerate

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // No grants while reset is held so nothing is reported as transferred.
    assign bus.req_ready = rst ? '0 : grant;

    logic [NUMER_W-1:0] sel_numer;
    logic [DENOM_W-1:0] sel_denom;
    logic               sel_dbz;

    assign sel_numer = numer_arr[grant_idx];
    assign sel_denom = denom_arr[grant_idx];
    assign sel_dbz   = (sel_denom == '0);

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // tag_reg[0] travels with the operand register; tag_reg[DIV_LATENCY] lines up
    // with the quotient the divider presents on div_quot.
    div_tag_t          tag_reg [DIV_LATENCY+1];
    logic [N_REQ-1:0]  resp_valid_reg;
    logic [QUOT_W-1:0] resp_quot_reg;
    logic              resp_dbz_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= '0;
            div_numer <= '0;
            div_denom <= DENOM_W'(1);
            for (int s = 0; s <= DIV_LATENCY; s++) begin
                tag_reg[s] <= '0;
            end
            resp_valid_reg <= '0;
            resp_quot_reg  <= '0;
            resp_dbz_reg   <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            if (grant_any) begin
                div_numer  <= sel_numer;
                div_denom  <= sel_dbz ? DENOM_W'(1) : sel_denom;
                tag_reg[0] <= '{vld: 1'b1, id: 3'(grant_idx), dbz: sel_dbz};
            end else begin
                tag_reg[0] <= '0;
            end
            for (int s = 1; s <= DIV_LATENCY; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
            resp_valid_reg <= tag_reg[DIV_LATENCY].vld ?
                              N_REQ'(onehot(tag_reg[DIV_LATENCY].id, N_REQ)) : '0;
            resp_quot_reg  <= tag_reg[DIV_LATENCY].dbz ? '0 : div_quot;
            resp_dbz_reg   <= tag_reg[DIV_LATENCY].dbz;
        end
    end

    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_quot  = resp_quot_reg;
    assign bus.resp_dbz   = resp_dbz_reg;

    always_comb begin
        busy = |resp_valid_reg;
        for (int s = 0; s <= DIV_LATENCY; s++) begin
            busy = busy | tag_reg[s].vld;
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: divider modelled as a DIV_LATENCY-deep operand pipeline,
// scoreboard queue filled on accept and drained on resp_valid.
module tb_div_share_arbiter;
    import div_arb_pkg::*;

    localparam int N_REQ       = 2;
    localparam int NUMER_W     = 23;
    localparam int DENOM_W     = 15;
    localparam int QUOT_W      = 11;
    localparam int DIV_LATENCY = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_share_arbiter_if #(
        .N_REQ(N_REQ), .NUMER_W(NUMER_W), .DENOM_W(DENOM_W), .QUOT_W(QUOT_W)
    ) bus ();

    logic [NUMER_W-1:0] div_numer;
    logic [DENOM_W-1:0] div_denom;
    logic [QUOT_W-1:0]  div_quot;
    logic               busy;

    div_share_arbiter #(
        .N_REQ(N_REQ), .NUMER_W(NUMER_W), .DENOM_W(DENOM_W),
        .QUOT_W(QUOT_W), .DIV_LATENCY(DIV_LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .div_numer (div_numer),
        .div_denom (div_denom),
        .div_quot  (div_quot),
        .busy      (busy)
    );

    // divide_ip model: operands delayed DIV_LATENCY edges, then divided
    logic [NUMER_W-1:0] pn [DIV_LATENCY];
    logic [DENOM_W-1:0] pd [DIV_LATENCY];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIV_LATENCY; i++) begin
                pn[i] <= '0;
                pd[i] <= DENOM_W'(1);
            end
        end else begin
            pn[0] <= div_numer;
            pd[0] <= div_denom;
            for (int i = 1; i < DIV_LATENCY; i++) begin
                pn[i] <= pn[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign div_quot = QUOT_W'(pn[DIV_LATENCY-1] / pd[DIV_LATENCY-1]);

    typedef struct {
        int                id;
        logic [QUOT_W-1:0] quot;
        logic              dbz;
        int                due;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   step_no      = 0;

    task automatic set_req(input int i, input bit v,
                           input logic [NUMER_W-1:0] n, input logic [DENOM_W-1:0] d);
        bus.req_valid[i] = v;
        bus.req_numer[i*NUMER_W +: NUMER_W] = n;
        bus.req_denom[i*DENOM_W +: DENOM_W] = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, '0, '0);
    endtask

    // One clock: sample transfers before the edge, check responses after it.
    task automatic step();
        exp_t e;
        logic [NUMER_W-1:0] n;
        logic [DENOM_W-1:0] d;
        logic [N_REQ-1:0]   exp_oh;
        #1;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.req_valid != '0) begin
                tests_run++;
                if (((bus.req_ready & ~bus.req_valid) != '0) || ($countones(bus.req_ready) > 1)) begin
                    tests_failed++;
                    $display("FAIL grant_legal step %0d: req_ready=%b req_valid=%b (need ready one-hot within valid)",
                             step_no, bus.req_ready, bus.req_valid);
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    n = bus.req_numer[i*NUMER_W +: NUMER_W];
                    d = bus.req_denom[i*DENOM_W +: DENOM_W];
                    e.id   = i;
                    e.dbz  = (d == '0);
                    e.quot = (d == '0) ? '0 : QUOT_W'(n / d);
                    e.due  = step_no + 1 + DIV_LATENCY + 1;
                    sb_q.push_back(e);
                end
            end
        end
        @(negedge clk);
        step_no++;
        if (bus.resp_valid != '0) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL resp_unexpected step %0d: resp_valid=%b, required none", step_no, bus.resp_valid);
            end else begin
                e = sb_q.pop_front();
                exp_oh = N_REQ'(1) << e.id;
                if (bus.resp_valid !== exp_oh || bus.resp_quot !== e.quot ||
                    bus.resp_dbz !== e.dbz || step_no != e.due) begin
                    tests_failed++;
                    $display("FAIL resp_match step %0d: valid=%b quot=%0d dbz=%b, required valid=%b quot=%0d dbz=%b at step %0d",
                             step_no, bus.resp_valid, bus.resp_quot, bus.resp_dbz,
                             exp_oh, e.quot, e.dbz, e.due);
                end
            end
        end else if (sb_q.size() > 0 && sb_q[0].due <= step_no) begin
            tests_run++;
            tests_failed++;
            $display("FAIL resp_missing step %0d: resp_valid=0, required response for req%0d due step %0d",
                     step_no, sb_q[0].id, sb_q[0].due);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || sb_q.size() > 0) && n < 60) begin
            step();
            n++;
        end
        tests_run++;
        if (busy || sb_q.size() > 0) begin
            tests_failed++;
            $display("FAIL drain: busy=%b pending=%0d after %0d cycles, required idle", busy, sb_q.size(), n);
        end
    endtask

    task automatic apply_reset();
        clear_reqs();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if (bus.req_ready !== '0 || bus.resp_valid !== '0 || bus.resp_quot !== '0 ||
            bus.resp_dbz !== 1'b0 || busy !== 1'b0 || div_numer !== '0 || div_denom !== DENOM_W'(1)) begin
            tests_failed++;
            $display("FAIL %s: ready=%b rv=%b rq=%0d dbz=%b busy=%b dn=%0d dd=%0d, required 0,0,0,0,0,0,1",
                     tag, bus.req_ready, bus.resp_valid, bus.resp_quot, bus.resp_dbz, busy, div_numer, div_denom);
        end
    endtask

    task automatic test_reset();
        clear_reqs();
        set_req(0, 1'b1, 23'd100, 15'd3);
        set_req(1, 1'b1, 23'd200, 15'd7);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        clear_reqs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 23'd6400, 15'd20);
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_ready: req_ready=%b, required 01", bus.req_ready);
        end
        step();
        clear_reqs();
        for (int j = 0; j <= DIV_LATENCY; j++) begin
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_busy cycle %0d: busy=%b, required 1", j, busy);
            end
            step();
        end
        tests_run++;
        if (bus.resp_valid !== 2'b01 || bus.resp_quot !== 11'd320 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_resp: valid=%b quot=%0d busy=%b, required 01 320 1",
                     bus.resp_valid, bus.resp_quot, busy);
        end
        drain();
    endtask

    task automatic test_alternate();
        logic [N_REQ-1:0] exp_rdy;
        apply_reset();
        set_req(0, 1'b1, 23'd1000, 15'd7);
        set_req(1, 1'b1, 23'd9999, 15'd33);
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
            tests_run++;
            if (bus.req_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL alternate_grant cycle %0d: req_ready=%b, required %b", c, bus.req_ready, exp_rdy);
            end
            step();
            set_req(0, 1'b1, 23'(1000 + 17 * c), 15'd7);
            set_req(1, 1'b1, 23'(9999 + 91 * c), 15'd33);
        end
        clear_reqs();
        drain();
    endtask

    task automatic test_dbz();
        set_req(1, 1'b1, 23'd500, 15'd0);
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL dbz_ready: req_ready=%b, required 10", bus.req_ready);
        end
        step();
        clear_reqs();
        tests_run++;
        if (div_denom !== DENOM_W'(1)) begin
            tests_failed++;
            $display("FAIL dbz_denom: div_denom=%0d, required 1", div_denom);
        end
        repeat (DIV_LATENCY + 1) step();
        tests_run++;
        if (bus.resp_valid !== 2'b10 || bus.resp_quot !== '0 || bus.resp_dbz !== 1'b1) begin
            tests_failed++;
            $display("FAIL dbz_resp: valid=%b quot=%0d dbz=%b, required 10 0 1",
                     bus.resp_valid, bus.resp_quot, bus.resp_dbz);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 9; c++) begin
            set_req(1, 1'b1, 23'(3000 + 123 * c), 15'(c + 2));
            #1;
            tests_run++;
            if (bus.req_ready !== 2'b10) begin
                tests_failed++;
                $display("FAIL stream_ready cycle %0d: req_ready=%b, required 10", c, bus.req_ready);
            end
            step();
        end
        clear_reqs();
        drain();
    endtask

    task automatic test_reset_midop();
        set_req(0, 1'b1, 23'd777, 15'd3);
        set_req(1, 1'b1, 23'd888, 15'd4);
        repeat (3) step();
        clear_reqs();
        repeat (2) step();
        rst = 1'b1;
        set_req(0, 1'b1, 23'd50, 15'd5);
        set_req(1, 1'b1, 23'd60, 15'd6);
        #1;
        check_reset_outputs("midop_in_reset");
        clear_reqs();
        repeat (2) step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            tests_run++;
            if (bus.resp_valid !== '0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL midop_quiet cycle %0d: resp_valid=%b busy=%b, required 00 0", c, bus.resp_valid, busy);
            end
        end
        set_req(0, 1'b1, 23'd90, 15'd9);
        set_req(1, 1'b1, 23'd80, 15'd8);
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL midop_next_grant: req_ready=%b, required 01", bus.req_ready);
        end
        step();
        clear_reqs();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                set_req(i, ($urandom_range(0, 9) < 6),
                        NUMER_W'($urandom),
                        ($urandom_range(0, 15) == 0) ? '0 : DENOM_W'($urandom_range(1, 32767)));
            end
            step();
        end
        clear_reqs();
        drain();
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_single();
        test_alternate();
        test_dbz();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
